// File: rtl/dds_pkg.sv
// Shared constants, state encoding and helpers for the DDS interpolator sequencer.
package dds_pkg;

  localparam int unsigned MODE_MAX = 4;
  localparam int unsigned MODE_W   = 4;
  localparam int unsigned MODE_IW  = $clog2(MODE_MAX + 1);
  localparam int unsigned SEG_W    = $clog2(10 ** MODE_MAX);

  // Segment lengths N = 10^k, indexed by the clamped mode.
  localparam logic [SEG_W-1:0] POW10 [MODE_MAX+1] = '{
    SEG_W'(1), SEG_W'(10), SEG_W'(100), SEG_W'(1000), SEG_W'(10000)
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME0,
    ST_PRIME1,
    ST_RUN
  } seq_state_e;

  function automatic logic [MODE_W-1:0] clamp_mode(input logic [MODE_W-1:0] m);
    return (m > MODE_W'(MODE_MAX)) ? MODE_W'(MODE_MAX) : m;
  endfunction

endpackage

// File: rtl/rom_fetch.sv
// Single-outstanding ROM request engine: rom_req rises with a stable address
// and holds until rom_valid; a new request may start on the completing edge.
module rom_fetch #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rom_valid,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_rom_req,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_done_c,
  output logic [DATA_W-1:0] o_data_c
);

  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              w_done;

  // Valid without an outstanding request is ignored.
  assign w_done     = r_req & i_rom_valid;
  assign o_done_c   = w_done;
  assign o_data_c   = i_rom_data;
  assign o_rom_req  = r_req;
  assign o_rom_addr = r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req  <= 1'b0;
      r_addr <= '0;
    end else if (i_start) begin
      r_req  <= 1'b1;
      r_addr <= i_addr;
    end else if (w_done) begin
      r_req  <= 1'b0;
    end
  end

endmodule

// File: rtl/interp_sequencer.sv
// Walks the sample ROM with a programmable step and hands the interpolator one
// (start, end) sample pair per segment of 10^Mode clocks with a load strobe.
module interp_sequencer
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              Run,
  input  logic [3:0]        Mode,
  input  logic [ADDR_W-1:0] Step,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out1,
  output logic [3:0]        ModeOut,
  output logic              Enable,
  output logic              Busy,
  output logic              Underrun
);

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sa;
  logic [DATA_W-1:0] r_sb;
  logic              r_sb_vld;
  logic [SEG_W-1:0]  r_seg;
  logic [SEG_W-1:0]  r_seg_last;
  logic [3:0]        r_mode;
  logic [DATA_W-1:0] r_out1;
  logic [DATA_W-1:0] r_out2;
  logic              r_enable;
  logic              r_busy;
  logic              r_underrun;
  logic              r_stop;
  logic              r_run_d;

  logic              w_start;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_done;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_addr_adv;
  logic              w_ready;
  logic [DATA_W-1:0] w_sb_next;
  logic              w_seg_end;
  logic              w_stop;
  logic              w_bnd;
  logic [3:0]        w_mode_c;
  logic [SEG_W-1:0]  w_seg_len_m1;

  rom_fetch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fetch (
    .i_clk      (Fg_CLK),
    .i_rst_n    (RESETn),
    .i_start    (w_start),
    .i_addr     (w_fetch_addr),
    .i_rom_valid(rom_valid),
    .i_rom_data (rom_data),
    .o_rom_req  (rom_req),
    .o_rom_addr (rom_addr),
    .o_done_c   (w_done),
    .o_data_c   (w_data)
  );

  assign w_addr_adv   = r_addr + Step;
  assign w_ready      = r_sb_vld | w_done;
  // Next sample may arrive on the very boundary cycle, so bypass the shadow.
  assign w_sb_next    = r_sb_vld ? r_sb : w_data;
  assign w_seg_end    = (r_seg == r_seg_last);
  assign w_stop       = r_stop | ~Run;
  assign w_mode_c     = clamp_mode(Mode);
  assign w_seg_len_m1 = POW10[MODE_IW'(w_mode_c)] - SEG_W'(1);
  assign w_bnd        = ((r_state == ST_PRIME1) && w_done) ||
                        ((r_state == ST_RUN) && w_seg_end && w_ready && !w_stop);

  // Fetch launch: first sample, second sample, then one prefetch per boundary.
  always_comb begin
    w_start      = 1'b0;
    w_fetch_addr = '0;
    if (w_bnd) begin
      w_start      = 1'b1;
      w_fetch_addr = w_addr_adv + Step;
    end else if ((r_state == ST_IDLE) && Run) begin
      w_start      = 1'b1;
      w_fetch_addr = '0;
    end else if ((r_state == ST_PRIME0) && w_done) begin
      w_start      = 1'b1;
      w_fetch_addr = w_addr_adv;
    end
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_sa       <= '0;
      r_sb       <= '0;
      r_sb_vld   <= 1'b0;
      r_seg      <= '0;
      r_seg_last <= '0;
      r_mode     <= '0;
      r_out1     <= '0;
      r_out2     <= '0;
      r_enable   <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_stop     <= 1'b0;
      r_run_d    <= 1'b0;
    end else begin
      r_run_d  <= Run;
      r_enable <= 1'b0;
      if (Run && !r_run_d) r_underrun <= 1'b0;

      if (w_bnd) begin
        r_out2     <= r_sa;
        r_out1     <= w_sb_next;
        r_mode     <= w_mode_c;
        r_seg_last <= w_seg_len_m1;
        r_seg      <= '0;
        r_enable   <= 1'b1;
        r_sa       <= w_sb_next;
        r_sb_vld   <= 1'b0;
        r_addr     <= w_addr_adv;
        r_state    <= ST_RUN;
        r_busy     <= 1'b1;
      end else if ((r_state == ST_RUN) && w_done) begin
        r_sb     <= w_data;
        r_sb_vld <= 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          r_addr <= '0;
          if (Run) begin
            r_state <= ST_PRIME0;
            r_busy  <= 1'b1;
            r_stop  <= 1'b0;
          end
        end
        ST_PRIME0: begin
          if (w_done) begin
            r_sa    <= w_data;
            r_state <= ST_PRIME1;
          end
        end
        ST_PRIME1: ;
        ST_RUN: begin
          if (!Run) r_stop <= 1'b1;
          // Stopping still drains the outstanding prefetch so IDLE never holds a request.
          if (w_seg_end) begin
            if (w_ready && w_stop) begin
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_sb_vld <= 1'b0;
              r_stop   <= 1'b0;
            end else if (!w_ready && !w_stop) begin
              r_underrun <= 1'b1;
            end
          end else begin
            r_seg <= r_seg + SEG_W'(1);
          end
        end
      endcase
    end
  end

  assign out1     = r_out1;
  assign out2     = r_out2;
  assign ModeOut  = r_mode;
  assign Enable   = r_enable;
  assign Busy     = r_busy;
  assign Underrun = r_underrun;

endmodule

// File: tb/tb_interp_sequencer.sv
// Self-checking bench for interp_sequencer: table-driven and randomized
// configurations against a segment-level model, plus multi-cycle corner cases.
module tb_interp_sequencer;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              Fg_CLK = 1'b0;
  logic              RESETn;
  logic              Run;
  logic [3:0]        Mode;
  logic [ADDR_W-1:0] Step;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_valid;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out1;
  logic [3:0]        ModeOut;
  logic              Enable;
  logic              Busy;
  logic              Underrun;

  interp_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Run(Run), .Mode(Mode), .Step(Step),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
    .out2(out2), .out1(out1), .ModeOut(ModeOut), .Enable(Enable), .Busy(Busy),
    .Underrun(Underrun)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  // ROM responder: answers each request `lat` cycles after it is raised.
  logic [DATA_W-1:0] rom_mem [1024];
  int   lat = 0;
  int   age;
  logic force_valid = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   stab_err = 0;
  logic [DATA_W*2+3:0] prev_out = '0;

  always @(posedge Fg_CLK or negedge RESETn)
    if (!RESETn)                 age <= 0;
    else if (rom_req && rom_valid) age <= 0;
    else if (rom_req)            age <= age + 1;
    else                         age <= 0;

  assign rom_valid = (rom_req && (age == lat)) || force_valid;
  assign rom_data  = rom_mem[rom_addr];

  always @(posedge Fg_CLK) cyc <= cyc + 1;

  // Outputs may only move on the Enable cycle.
  always @(negedge Fg_CLK) begin
    if (RESETn && !Enable && ({out2, out1, ModeOut} != prev_out)) stab_err <= stab_err + 1;
    prev_out <= {out2, out1, ModeOut};
  end

  typedef struct {
    int mode; int step; int lat; int nseg;
    int first; int period; int mode_out; int under;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Segment-level reference model.
  function automatic int m_clamp(input int m);
    return (m > 4) ? 4 : m;
  endfunction
  function automatic int m_period(input int m, input int l);
    int n;
    n = 10 ** m_clamp(m);
    return (n > l + 1) ? n : l + 1;
  endfunction
  function automatic int m_under(input int m, input int l);
    return (l + 1 > 10 ** m_clamp(m)) ? 1 : 0;
  endfunction
  function automatic logic [DATA_W-1:0] m_sample(input int k, input int step);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(k * step);
    return rom_mem[a];
  endfunction

  task automatic wait_enable(input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Fg_CLK);
      if (Enable) begin
        t  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Fg_CLK);
      if (!Busy) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, " idle"}, 64'(done), 64'd1);
  endtask

  task automatic run_cfg(input vec_t c, input string tag);
    int t_run, t;
    bit ok;
    @(negedge Fg_CLK);
    Mode = 4'(c.mode);
    Step = ADDR_W'(c.step);
    lat  = c.lat;
    Run  = 1'b1;
    t_run = cyc;
    for (int k = 0; k < c.nseg; k++) begin
      wait_enable((k == 0 ? c.first : c.period) + 20, t, ok);
      if (!ok) begin
        check($sformatf("%s seg%0d enable timeout", tag, k), 64'd0, 64'd1);
        break;
      end
      check($sformatf("%s seg%0d time", tag, k), 64'(t - t_run), 64'(c.first + k * c.period));
      check($sformatf("%s seg%0d out2", tag, k), 64'(out2), 64'(m_sample(k, c.step)));
      check($sformatf("%s seg%0d out1", tag, k), 64'(out1), 64'(m_sample(k + 1, c.step)));
      check($sformatf("%s seg%0d mode", tag, k), 64'(ModeOut), 64'(c.mode_out));
    end
    check({tag, " underrun"}, 64'(Underrun), 64'(c.under));
    Run = 1'b0;
    wait_idle(c.period + c.lat + 30, tag);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, en_cnt;
    bit ok, flag;
    logic [DATA_W-1:0] s1, s2;
    logic [3:0] sm;
    vec_t v;

    tbl[0] = '{1, 1, 0,   5,  3,    10, 1, 0};
    tbl[1] = '{0, 1, 2,   5,  7,     3, 0, 1};
    tbl[2] = '{0, 1, 0,   8,  3,     1, 0, 0};
    tbl[3] = '{2, 7, 5,   3, 13,   100, 2, 0};
    tbl[4] = '{1, 2, 12,  4, 27,    13, 1, 1};
    tbl[5] = '{9, 5, 1,   2,  5, 10000, 4, 0};
    tbl[6] = '{0, 3, 0, 344,  3,     1, 0, 0};

    for (int i = 0; i < 1024; i++) rom_mem[i] = DATA_W'(i) << 18;

    RESETn = 1'b0; Run = 1'b0; Mode = '0; Step = '0;
    repeat (3) @(negedge Fg_CLK);
    check("reset ctrl", 64'({rom_req, Busy, Enable, Underrun, ModeOut, rom_addr}), 64'd0);
    check("reset out1", 64'(out1), 64'd0);
    check("reset out2", 64'(out2), 64'd0);
    RESETn = 1'b1;
    @(negedge Fg_CLK);
    check("idle after reset", 64'({rom_req, Busy, Enable}), 64'd0);

    for (int i = 0; i < 7; i++) run_cfg(tbl[i], $sformatf("tbl%0d", i));

    // Mode change mid-segment takes effect at the next boundary only.
    @(negedge Fg_CLK);
    Mode = 4'd1; Step = ADDR_W'(1); lat = 0; Run = 1'b1;
    wait_enable(30, t0, ok);
    repeat (5) @(negedge Fg_CLK);
    Mode = 4'd2;
    wait_enable(30, t1, ok);
    check("modechg old period", 64'(t1 - t0), 64'd10);
    check("modechg modeout", 64'(ModeOut), 64'd2);
    wait_enable(130, t2, ok);
    check("modechg new period", 64'(t2 - t1), 64'd100);
    Run = 1'b0;
    wait_idle(150, "modechg");

    // Run dropped at seg_cnt=4: segment completes, no further Enable.
    @(negedge Fg_CLK);
    Mode = 4'd1; Step = ADDR_W'(1); lat = 0; Run = 1'b1;
    wait_enable(30, t0, ok);
    s1 = out1; s2 = out2; sm = ModeOut;
    en_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge Fg_CLK);
      else @(negedge Fg_CLK);
      if (c == 4) Run = 1'b0;
      if (Enable) en_cnt++;
      if (c == 9)  check("stop busy cycle9", 64'(Busy), 64'd1);
      if (c == 10) check("stop busy cycle10", 64'(Busy), 64'd0);
    end
    check("stop no enable", 64'(en_cnt), 64'd0);
    check("stop out1 held", 64'(out1), 64'(s1));
    check("stop out2 held", 64'(out2), 64'(s2));
    check("stop mode held", 64'(ModeOut), 64'(sm));

    // Randomized configurations and ROM contents against the model.
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom();
    for (int r = 0; r < 6; r++) begin
      v.mode     = int'($urandom_range(0, 2));
      v.lat      = int'($urandom_range(0, 6));
      v.step     = int'($urandom_range(0, 1023));
      v.nseg     = int'($urandom_range(3, 5));
      v.first    = 2 * v.lat + 3;
      v.period   = m_period(v.mode, v.lat);
      v.mode_out = m_clamp(v.mode);
      v.under    = m_under(v.mode, v.lat);
      run_cfg(v, $sformatf("rnd%0d", r));
    end

    // Reset while a prefetch is outstanding.
    @(negedge Fg_CLK);
    Mode = 4'd1; Step = ADDR_W'(1); lat = 6; Run = 1'b1;
    wait_enable(40, t0, ok);
    wait_enable(40, t1, ok);
    repeat (2) @(negedge Fg_CLK);
    check("req before reset", 64'(rom_req), 64'd1);
    #2 RESETn = 1'b0;
    #1;
    check("async reset ctrl", 64'({rom_req, Busy, Enable, Underrun, ModeOut, rom_addr}), 64'd0);
    check("async reset out1", 64'(out1), 64'd0);
    check("async reset out2", 64'(out2), 64'd0);
    Run = 1'b0;
    force_valid = 1'b1;
    flag = 1'b0;
    repeat (2) @(negedge Fg_CLK);
    RESETn = 1'b1;
    repeat (3) begin
      @(negedge Fg_CLK);
      if (rom_req || Busy || Enable) flag = 1'b1;
    end
    force_valid = 1'b0;
    check("late valid ignored", 64'(flag), 64'd0);
    v = '{1, 1, 0, 2, 3, 10, 1, 0};
    run_cfg(v, "restart");

    check("outputs stable in segment", 64'(stab_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
